seg_scan_controller: RTL



---
 rtl/seg_scan_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller: walks NUM_DIGITS BCD digits over one shared
// encoder, with a blanking window at the start of each slot and tear-free double buffering.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lz_en,
    output logic [3:0]              digit_code,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    dp_n,
    output logic                    frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [NUM_DIGITS-1:0]   dpActive_q, dpActive_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   pendDp_q, pendDp_d;
    logic                    pendValid_q, pendValid_d;

    logic [3:0]              code_q, code_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    dpn_q, dpn_d;
    logic                    frameDone_q, frameDone_d;

    logic                    slotEnd;
    logic                    frameWrap;
    logic [3:0]              digitArr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zeroFrom;

    assign slotEnd   = (cnt_q == CNT_LAST);
    assign frameWrap = slotEnd && (idx_q == IDX_LAST);

    always_comb begin
        cnt_d = slotEnd ? '0 : cnt_q + CNT_W'(1);
        idx_d = idx_q;
        if (slotEnd) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Active digits only change on the frame wrap so a frame never shows a mix of old and new.
    always_comb begin
        active_d    = active_q;
        dpActive_d  = dpActive_q;
        pend_d      = pend_q;
        pendDp_d    = pendDp_q;
        pendValid_d = pendValid_q;
        if (frameWrap) begin
            if (load) begin
                active_d   = digits_in;
                dpActive_d = dp_in;
            end else if (pendValid_q) begin
                active_d   = pend_q;
                dpActive_d = pendDp_q;
            end
            pendValid_d = 1'b0;
        end else if (load) begin
            pend_d      = digits_in;
            pendDp_d    = dp_in;
            pendValid_d = 1'b1;
        end
    end

    // zeroFrom[i] is set when digit i and every more significant digit are zero.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digitArr[i] = active_q[4*i +: 4];
            zeroFrom[i] = ((active_q >> (4*i)) == '0);
        end
    end

    always_comb begin
        anode_d     = '1;
        code_d      = 4'hF;
        dpn_d       = 1'b1;
        frameDone_d = frameWrap;
        if (cnt_q >= BLANK_END) begin
            anode_d[idx_q] = 1'b0;
            code_d = (lz_en && (idx_q != '0) && zeroFrom[idx_q]) ? 4'hF : digitArr[idx_q];
            dpn_d  = ~dpActive_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            dpActive_q  <= '0;
            pend_q      <= '0;
            pendDp_q    <= '0;
            pendValid_q <= 1'b0;
            code_q      <= 4'hF;
            anode_q     <= '1;
            dpn_q       <= 1'b1;
            frameDone_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            dpActive_q  <= dpActive_d;
            pend_q      <= pend_d;
            pendDp_q    <= pendDp_d;
            pendValid_q <= pendValid_d;
            code_q      <= code_d;
            anode_q     <= anode_d;
            dpn_q       <= dpn_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign digit_code = code_q;
    assign anode_n    = anode_q;
    assign dp_n       = dpn_q;
    assign frame_done = frameDone_q;

endmodule
